// File: rtl/issue_window_scheduler_pkg.sv
// Shared types and constants for the issue window between decode and issue.
package issue_window_scheduler_pkg;

   localparam int unsigned ISSUE_WIN_DEPTH      = 4;
   localparam int unsigned ISSUE_WIN_MAX_BYPASS = 10;
   localparam int unsigned REG_ADDR_BITS        = 5;
   localparam int unsigned PC_BITS              = 32;

   typedef enum logic [3:0] {
      NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU
   } fu_t;

   typedef struct packed {
      logic [PC_BITS-1:0]       pc;
      fu_t                      fu;
      logic [REG_ADDR_BITS-1:0] rs1;
      logic [REG_ADDR_BITS-1:0] rs2;
      logic [REG_ADDR_BITS-1:0] rd;
   } scoreboard_entry_t;

   typedef struct packed {
      scoreboard_entry_t sbe;
      logic              is_ctrl_flow;
      logic              valid;
   } issue_slot_t;

   // Memory ops are the only entries that may be bypassed.
   function automatic logic is_mem_op(fu_t fu);
      return (fu == LOAD) || (fu == STORE);
   endfunction

   // Entries allowed to overtake a memory op in slot 0.
   function automatic logic is_bypass_fu(fu_t fu);
      return !((fu == LOAD) || (fu == STORE) || (fu == CTRL_FLOW));
   endfunction

endpackage

// File: rtl/issue_window_scheduler_if.sv
// Decoded-entry handshake: master presents an entry, slave acknowledges it.
interface issue_window_scheduler_if;
   import issue_window_scheduler_pkg::*;

   scoreboard_entry_t entry;
   logic              valid;
   logic              is_ctrl_flow;
   logic              ack;

   modport master (output entry, output valid, output is_ctrl_flow, input ack);
   modport slave  (input entry, input valid, input is_ctrl_flow, output ack);
endinterface

// File: rtl/issue_window_scheduler_hazard_check.sv
// Register-dependency check of one bypass candidate against one older entry.
// x0 is compared like any other register, which keeps the check conservative.
module issue_window_scheduler_hazard_check
   import issue_window_scheduler_pkg::*;
(
   input  logic [REG_ADDR_BITS-1:0] cand_rs1_i,
   input  logic [REG_ADDR_BITS-1:0] cand_rs2_i,
   input  logic [REG_ADDR_BITS-1:0] cand_rd_i,
   input  logic [REG_ADDR_BITS-1:0] older_rs1_i,
   input  logic [REG_ADDR_BITS-1:0] older_rs2_i,
   input  logic [REG_ADDR_BITS-1:0] older_rd_i,
   output logic                     hazard_o
);

   // RAW, WAR and WAW between the pair.
   assign hazard_o = (cand_rs1_i == older_rd_i)  |
                     (cand_rs2_i == older_rd_i)  |
                     (cand_rd_i  == older_rs1_i) |
                     (cand_rd_i  == older_rs2_i) |
                     (cand_rd_i  == older_rd_i);

endmodule

// File: rtl/issue_window_scheduler.sv
// Small compacting issue window. Issues the oldest entry, except that a
// hazard-free ALU-type entry may overtake a memory op sitting in slot 0,
// at most MAX_BYPASS times per memory op.
module issue_window_scheduler
   import issue_window_scheduler_pkg::*;
#(
   parameter int unsigned DEPTH      = ISSUE_WIN_DEPTH,
   parameter int unsigned MAX_BYPASS = ISSUE_WIN_MAX_BYPASS
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             flush_i,
   input  logic                             debug_req_i,
   issue_window_scheduler_if.slave          id_if,
   issue_window_scheduler_if.master         is_if
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned BYP_W = $clog2(MAX_BYPASS + 1);
   localparam int unsigned SEL_W = $clog2(DEPTH);

   issue_slot_t        slots_q [DEPTH];
   issue_slot_t        slots_d [DEPTH];
   logic [CNT_W-1:0]   count_q, count_d;
   logic [BYP_W-1:0]   bypass_cnt_q, bypass_cnt_d;

   logic [SEL_W-1:0]   sel;
   logic               sel_found;
   logic               sel_blocked;
   logic               bypass_ok;
   logic [DEPTH-1:0]   cand_haz;
   logic               deq;
   logic [CNT_W-1:0]   cnt_tmp;

   // Slot 0 can never be a bypass candidate.
   assign cand_haz[0] = 1'b1;

   // Per-candidate hazard against every older slot.
   for (genvar j = 1; j < DEPTH; j++) begin : g_cand
      logic [DEPTH-1:0] pair_haz;
      for (genvar k = 0; k < DEPTH; k++) begin : g_older
         if (k < j) begin : g_chk
            issue_window_scheduler_hazard_check i_hazard_check (
               .cand_rs1_i  (slots_q[j].sbe.rs1),
               .cand_rs2_i  (slots_q[j].sbe.rs2),
               .cand_rd_i   (slots_q[j].sbe.rd),
               .older_rs1_i (slots_q[k].sbe.rs1),
               .older_rs2_i (slots_q[k].sbe.rs2),
               .older_rd_i  (slots_q[k].sbe.rd),
               .hazard_o    (pair_haz[k])
            );
         end else begin : g_none
            assign pair_haz[k] = 1'b0;
         end
      end
      assign cand_haz[j] = |pair_haz;
   end

   // Select the oldest entry, or the first eligible younger one past a memory op.
   always_comb begin
      sel         = '0;
      sel_found   = 1'b0;
      sel_blocked = 1'b0;
      bypass_ok   = slots_q[0].valid & is_mem_op(slots_q[0].sbe.fu) & ~debug_req_i &
                    (bypass_cnt_q < BYP_W'(MAX_BYPASS));
      for (int j = 0; j < DEPTH; j++) begin
         if (bypass_ok && !sel_found && !sel_blocked && slots_q[j].valid &&
             is_bypass_fu(slots_q[j].sbe.fu) && !cand_haz[j]) begin
            sel       = SEL_W'(j);
            sel_found = 1'b1;
         end
         if (j > 0 && slots_q[j].valid && slots_q[j].sbe.fu == CTRL_FLOW) begin
            sel_blocked = 1'b1;
         end
      end
   end

   // Handshakes and issue-side view of the selected slot.
   assign is_if.valid        = (count_q != '0);
   assign is_if.entry        = slots_q[sel].valid ? slots_q[sel].sbe : '0;
   assign is_if.is_ctrl_flow = slots_q[sel].valid & slots_q[sel].is_ctrl_flow;
   assign id_if.ack          = id_if.valid & ~flush_i &
                               ((count_q < CNT_W'(DEPTH)) | is_if.ack);
   assign deq                = is_if.ack & is_if.valid;

   // Next window state: flush, else dequeue with compaction, then enqueue at the tail.
   always_comb begin
      slots_d      = slots_q;
      count_d      = count_q;
      bypass_cnt_d = bypass_cnt_q;
      cnt_tmp      = count_q;
      if (flush_i) begin
         slots_d      = '{default: '0};
         count_d      = '0;
         bypass_cnt_d = '0;
      end else begin
         if (deq) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               if (SEL_W'(i) >= sel) begin
                  slots_d[i] = slots_q[i + 1];
               end
            end
            slots_d[DEPTH-1] = '0;
            cnt_tmp          = count_q - CNT_W'(1);
            if (sel != '0) begin
               if (bypass_cnt_q < BYP_W'(MAX_BYPASS)) begin
                  bypass_cnt_d = bypass_cnt_q + BYP_W'(1);
               end
            end else begin
               bypass_cnt_d = '0;
            end
         end
         if (id_if.ack) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (CNT_W'(i) == cnt_tmp) begin
                  slots_d[i] = '{sbe: id_if.entry, is_ctrl_flow: id_if.is_ctrl_flow, valid: 1'b1};
               end
            end
            cnt_tmp = cnt_tmp + CNT_W'(1);
         end
         count_d = cnt_tmp;
         if (!(slots_d[0].valid && is_mem_op(slots_d[0].sbe.fu))) begin
            bypass_cnt_d = '0;
         end
      end
   end

   // Window state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slots_q      <= '{default: '0};
         count_q      <= '0;
         bypass_cnt_q <= '0;
      end else begin
         slots_q      <= slots_d;
         count_q      <= count_d;
         bypass_cnt_q <= bypass_cnt_d;
      end
   end

endmodule

// File: tb/tb_issue_window_scheduler.sv
// Directed bench for the issue window scheduler.
module tb_issue_window_scheduler;
   import issue_window_scheduler_pkg::*;

   logic clk_i = 1'b0;
   logic rst_ni;
   logic flush_i;
   logic debug_req_i;

   issue_window_scheduler_if id_if ();
   issue_window_scheduler_if is_if ();

   issue_window_scheduler dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .debug_req_i (debug_req_i),
      .id_if       (id_if),
      .is_if       (is_if)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   scoreboard_entry_t tx_q[$];
   logic              tx_cf_q[$];
   scoreboard_entry_t rx_q[$];
   logic              rx_cf_q[$];
   logic              ack_en;

   function automatic scoreboard_entry_t mk(input logic [31:0] pc, input fu_t fu,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
      scoreboard_entry_t e;
      e.pc = pc; e.fu = fu; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
      return e;
   endfunction

   task automatic push(input scoreboard_entry_t e, input logic cf);
      tx_q.push_back(e);
      tx_cf_q.push_back(cf);
   endtask

   // Drive queued entries, acknowledge per ack_en, and log issued entries.
   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         logic acked;
         if (tx_q.size() > 0) begin
            id_if.entry = tx_q[0]; id_if.is_ctrl_flow = tx_cf_q[0]; id_if.valid = 1'b1;
         end else begin
            id_if.entry = '0; id_if.is_ctrl_flow = 1'b0; id_if.valid = 1'b0;
         end
         is_if.ack = ack_en;
         #1;
         if (is_if.valid && is_if.ack) begin
            rx_q.push_back(is_if.entry);
            rx_cf_q.push_back(is_if.is_ctrl_flow);
         end
         acked = id_if.ack;
         @(posedge clk_i); #1;
         if (acked) begin
            void'(tx_q.pop_front());
            void'(tx_cf_q.pop_front());
         end
      end
   endtask

   task automatic drain();
      ack_en = 1'b1;
      run(8);
      tx_q.delete(); tx_cf_q.delete(); rx_q.delete(); rx_cf_q.delete();
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; flush_i = 1'b0; debug_req_i = 1'b0;
      id_if.entry = '0; id_if.valid = 1'b0; id_if.is_ctrl_flow = 1'b0; is_if.ack = 1'b0;
      ack_en = 1'b0;
      #2;
      checks++; if (is_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid_o got=%b exp=0", is_if.valid); end
      checks++; if (id_if.ack !== 1'b0) begin errors++; $display("FAIL reset_ack_o got=%b exp=0", id_if.ack); end
      checks++; if (is_if.entry !== '0) begin errors++; $display("FAIL reset_entry_o got=%h exp=0", is_if.entry); end
      checks++; if (is_if.is_ctrl_flow !== 1'b0) begin errors++; $display("FAIL reset_cf_o got=%b exp=0", is_if.is_ctrl_flow); end
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(posedge clk_i); #1;
      checks++; if (is_if.valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid_o got=%b exp=0", is_if.valid); end
      checks++; if (is_if.entry !== '0) begin errors++; $display("FAIL post_reset_entry_o got=%h exp=0", is_if.entry); end
   endtask

   task automatic test_in_order();
      is_if.ack = 1'b1;
      id_if.entry = mk(32'h100, ALU, 5'd6, 5'd1, 5'd2); id_if.valid = 1'b1; id_if.is_ctrl_flow = 1'b0;
      #1;
      checks++; if (id_if.ack !== 1'b1) begin errors++; $display("FAIL inorder_ack_add got=%b exp=1", id_if.ack); end
      checks++; if (is_if.valid !== 1'b0) begin errors++; $display("FAIL inorder_valid_early got=%b exp=0", is_if.valid); end
      @(posedge clk_i); #1;
      id_if.entry = mk(32'h104, ALU, 5'd7, 5'd3, 5'd4);
      #1;
      checks++; if (is_if.valid !== 1'b1 || is_if.entry.pc !== 32'h100) begin errors++; $display("FAIL inorder_first got=%b/%h exp=1/100", is_if.valid, is_if.entry.pc); end
      checks++; if (id_if.ack !== 1'b1) begin errors++; $display("FAIL inorder_ack_sub got=%b exp=1", id_if.ack); end
      @(posedge clk_i); #1;
      id_if.valid = 1'b0; id_if.entry = '0;
      #1;
      checks++; if (is_if.valid !== 1'b1 || is_if.entry.pc !== 32'h104) begin errors++; $display("FAIL inorder_second got=%b/%h exp=1/104", is_if.valid, is_if.entry.pc); end
      @(posedge clk_i); #1;
      checks++; if (is_if.valid !== 1'b0) begin errors++; $display("FAIL inorder_empty got=%b exp=0", is_if.valid); end
      is_if.ack = 1'b0;
   endtask

   task automatic test_bypass();
      push(mk(32'h200, LOAD, 5'd5, 5'd3, 5'd0), 1'b0);
      push(mk(32'h204, ALU, 5'd6, 5'd1, 5'd2), 1'b0);
      ack_en = 1'b0; run(3);
      ack_en = 1'b1; run(4);
      checks++;
      if (rx_q.size() != 2) begin errors++; $display("FAIL bypass_count got=%0d exp=2", rx_q.size()); end
      else if (rx_q[0].pc !== 32'h204 || rx_q[1].pc !== 32'h200) begin
         errors++; $display("FAIL bypass_order got=%h,%h exp=204,200", rx_q[0].pc, rx_q[1].pc);
      end
      drain();
   endtask

   task automatic test_hazards();
      push(mk(32'h220, LOAD, 5'd5, 5'd3, 5'd0), 1'b0);
      push(mk(32'h224, ALU, 5'd6, 5'd5, 5'd1), 1'b0);
      ack_en = 1'b0; run(3);
      ack_en = 1'b1; run(4);
      checks++;
      if (rx_q.size() != 2) begin errors++; $display("FAIL raw_count got=%0d exp=2", rx_q.size()); end
      else if (rx_q[0].pc !== 32'h220 || rx_q[1].pc !== 32'h224) begin
         errors++; $display("FAIL raw_order got=%h,%h exp=220,224", rx_q[0].pc, rx_q[1].pc);
      end
      drain();
      push(mk(32'h240, LOAD, 5'd5, 5'd3, 5'd0), 1'b0);
      push(mk(32'h244, CTRL_FLOW, 5'd0, 5'd1, 5'd2), 1'b1);
      push(mk(32'h248, ALU, 5'd6, 5'd1, 5'd2), 1'b0);
      ack_en = 1'b0; run(4);
      ack_en = 1'b1; run(5);
      checks++;
      if (rx_q.size() != 3) begin errors++; $display("FAIL ctrl_count got=%0d exp=3", rx_q.size()); end
      else if (rx_q[0].pc !== 32'h240 || rx_q[1].pc !== 32'h244 || rx_q[2].pc !== 32'h248) begin
         errors++; $display("FAIL ctrl_order got=%h,%h,%h exp=240,244,248", rx_q[0].pc, rx_q[1].pc, rx_q[2].pc);
      end
      checks++;
      if (rx_cf_q.size() != 3) begin errors++; $display("FAIL ctrl_flag_count got=%0d exp=3", rx_cf_q.size()); end
      else if (rx_cf_q[1] !== 1'b1 || rx_cf_q[0] !== 1'b0) begin
         errors++; $display("FAIL ctrl_flag got=%b,%b exp=0,1", rx_cf_q[0], rx_cf_q[1]);
      end
      drain();
   endtask

   task automatic test_max_bypass();
      push(mk(32'h300, LOAD, 5'd5, 5'd3, 5'd0), 1'b0);
      for (int i = 0; i < 12; i++) push(mk(32'h400 + 32'(4*i), ALU, 5'(10 + i), 5'd1, 5'd2), 1'b0);
      ack_en = 1'b0; run(4);
      ack_en = 1'b1; run(20);
      checks++;
      if (rx_q.size() != 13) begin errors++; $display("FAIL maxbyp_count got=%0d exp=13", rx_q.size()); end
      else begin
         for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx_q[i].pc !== 32'h400 + 32'(4*i)) begin errors++; $display("FAIL maxbyp_alu%0d got=%h exp=%h", i, rx_q[i].pc, 32'h400 + 32'(4*i)); end
         end
         checks++;
         if (rx_q[10].pc !== 32'h300) begin errors++; $display("FAIL maxbyp_load got=%h exp=300", rx_q[10].pc); end
         checks++;
         if (rx_q[11].pc !== 32'h428 || rx_q[12].pc !== 32'h42c) begin errors++; $display("FAIL maxbyp_tail got=%h,%h exp=428,42c", rx_q[11].pc, rx_q[12].pc); end
      end
      drain();
      debug_req_i = 1'b1;
      push(mk(32'h500, LOAD, 5'd5, 5'd3, 5'd0), 1'b0);
      for (int i = 0; i < 3; i++) push(mk(32'h504 + 32'(4*i), ALU, 5'(10 + i), 5'd1, 5'd2), 1'b0);
      ack_en = 1'b0; run(4);
      ack_en = 1'b1; run(6);
      checks++;
      if (rx_q.size() != 4) begin errors++; $display("FAIL debug_count got=%0d exp=4", rx_q.size()); end
      else if (rx_q[0].pc !== 32'h500 || rx_q[1].pc !== 32'h504 || rx_q[3].pc !== 32'h50c) begin
         errors++; $display("FAIL debug_order got=%h,%h,%h exp=500,504,50c", rx_q[0].pc, rx_q[1].pc, rx_q[3].pc);
      end
      debug_req_i = 1'b0;
      drain();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) push(mk(32'h600 + 32'(4*i), ALU, 5'(10 + i), 5'd1, 5'd2), 1'b0);
      ack_en = 1'b0; run(4);
      checks++;
      if (tx_q.size() != 1) begin errors++; $display("FAIL full_stall got=%0d exp=1", tx_q.size()); end
      ack_en = 1'b1; run(1);
      checks++;
      if (tx_q.size() != 0) begin errors++; $display("FAIL full_deq_enq got=%0d exp=0", tx_q.size()); end
      run(6);
      checks++;
      if (rx_q.size() != 5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", rx_q.size()); end
      else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_q[i].pc !== 32'h600 + 32'(4*i)) begin errors++; $display("FAIL b2b_order%0d got=%h exp=%h", i, rx_q[i].pc, 32'h600 + 32'(4*i)); end
         end
      end
      drain();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) push(mk(32'h700 + 32'(4*i), ALU, 5'(10 + i), 5'd1, 5'd2), 1'b0);
      ack_en = 1'b0; run(3);
      flush_i = 1'b1;
      id_if.entry = mk(32'h7f0, ALU, 5'd20, 5'd1, 5'd2); id_if.valid = 1'b1; is_if.ack = 1'b0;
      #1;
      checks++; if (id_if.ack !== 1'b0) begin errors++; $display("FAIL flush_ack_o got=%b exp=0", id_if.ack); end
      checks++; if (is_if.valid !== 1'b1) begin errors++; $display("FAIL flush_cycle_valid got=%b exp=1", is_if.valid); end
      @(posedge clk_i); #1;
      flush_i = 1'b0; id_if.valid = 1'b0; id_if.entry = '0;
      #1;
      checks++; if (is_if.valid !== 1'b0) begin errors++; $display("FAIL flush_valid_o got=%b exp=0", is_if.valid); end
      checks++; if (dut.count_q !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", dut.count_q); end
      push(mk(32'h800, ALU, 5'd9, 5'd1, 5'd2), 1'b0);
      ack_en = 1'b1; run(3);
      checks++;
      if (rx_q.size() != 1) begin errors++; $display("FAIL post_flush_count got=%0d exp=1", rx_q.size()); end
      else if (rx_q[0].pc !== 32'h800) begin errors++; $display("FAIL post_flush_entry got=%h exp=800", rx_q[0].pc); end
      drain();
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_bypass();
      test_hazards();
      test_max_bypass();
      test_back_to_back();
      test_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
